// File: rtl/game_control.sv
// game_control: Reversi command-side FSM that issues one datapath enable at a time over a
// go handshake, with a per-state watchdog that traps a stalled datapath in ERROR.
module game_control #(
    parameter int TO_W = 20
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enter,
    input  logic       right,
    input  logic       left,
    input  logic       up,
    input  logic       down,
    input  logic       go,
    input  logic       validMove,
    input  logic       hasTurn,
    output logic       dpReset,
    output logic       drawBoardEn,
    output logic       drawInitialPiecesEn,
    output logic       moveRightEn,
    output logic       moveLeftEn,
    output logic       moveUpEn,
    output logic       moveDownEn,
    output logic       moveHighlightEn,
    output logic       checkIfValidMoveEn,
    output logic       placeEn,
    output logic       flipEn,
    output logic       scoreManagerEn,
    output logic       determineHasTurnEn,
    output logic       determineCurrent,
    output logic       determineOpponent,
    output logic       TurnManagerEn,
    output logic       removeHighlightEn,
    output logic       writeEn,
    output logic       player,
    output logic       gameOver,
    output logic       error,
    output logic [4:0] state
);
    typedef enum logic [4:0] {
        S_RESET, S_DRAW_BOARD, S_DRAW_INIT, S_DRAW_HL, S_IDLE,
        S_MOVE_R, S_MOVE_L, S_MOVE_U, S_MOVE_D, S_CHECK,
        S_PLACE, S_FLIP, S_SCORE, S_TURN, S_HAS_CUR,
        S_HAS_OPP, S_PASS, S_REMOVE_HL, S_GAME_OVER, S_ERROR
    } state_t;

    localparam int O_DPRESET = 19, O_BOARD = 18, O_INIT = 17, O_MR = 16, O_ML = 15;
    localparam int O_MU = 14, O_MD = 13, O_HL = 12, O_CHECK = 11, O_PLACE = 10;
    localparam int O_FLIP = 9, O_SCORE = 8, O_HAS = 7, O_CUR = 6, O_OPP = 5;
    localparam int O_TURN = 4, O_RMHL = 3, O_WRITE = 2, O_OVER = 1, O_ERROR = 0;

    // Counter value one short of all-ones: the edge leaving it is the one that reaches the limit.
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};
    localparam logic [TO_W-1:0] TO_MAX  = '1;

    state_t          state_q, state_d;
    logic [TO_W-1:0] wdog_q, wdog_d;
    logic            player_q, player_d;
    logic [19:0]     out_q;
    logic            waiting;
    logic            advance;

    function automatic logic [19:0] decode(state_t s);
        logic [19:0] o;
        o = '0;
        case (s)
            S_RESET:      o[O_DPRESET] = 1'b1;
            S_DRAW_BOARD: begin o[O_BOARD] = 1'b1; o[O_WRITE] = 1'b1; end
            S_DRAW_INIT:  begin o[O_INIT]  = 1'b1; o[O_WRITE] = 1'b1; end
            S_DRAW_HL:    begin o[O_HL]    = 1'b1; o[O_WRITE] = 1'b1; end
            S_MOVE_R:     o[O_MR] = 1'b1;
            S_MOVE_L:     o[O_ML] = 1'b1;
            S_MOVE_U:     o[O_MU] = 1'b1;
            S_MOVE_D:     o[O_MD] = 1'b1;
            S_CHECK:      o[O_CHECK] = 1'b1;
            S_PLACE:      o[O_PLACE] = 1'b1;
            S_FLIP:       begin o[O_FLIP]  = 1'b1; o[O_WRITE] = 1'b1; end
            S_SCORE:      begin o[O_SCORE] = 1'b1; o[O_WRITE] = 1'b1; end
            S_TURN:       o[O_TURN] = 1'b1;
            S_HAS_CUR:    begin o[O_HAS] = 1'b1; o[O_CUR] = 1'b1; end
            S_HAS_OPP:    begin o[O_HAS] = 1'b1; o[O_OPP] = 1'b1; end
            S_PASS:       o[O_TURN] = 1'b1;
            S_REMOVE_HL:  begin o[O_RMHL] = 1'b1; o[O_WRITE] = 1'b1; end
            S_GAME_OVER:  o[O_OVER]  = 1'b1;
            S_ERROR:      o[O_ERROR] = 1'b1;
            default:      o = '0;
        endcase
        return o;
    endfunction

    always_comb begin
        case (state_q)
            S_RESET, S_DRAW_BOARD, S_DRAW_INIT, S_DRAW_HL, S_CHECK, S_PLACE, S_FLIP,
            S_SCORE, S_TURN, S_HAS_CUR, S_HAS_OPP, S_PASS, S_REMOVE_HL: waiting = 1'b1;
            default:                                                     waiting = 1'b0;
        endcase
    end

    // A zero count marks the settle cycle, so a stale go from the previous enable is ignored.
    assign advance = waiting && (wdog_q != '0) && go;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:      if (advance) state_d = S_DRAW_BOARD;
            S_DRAW_BOARD: if (advance) state_d = S_DRAW_INIT;
            S_DRAW_INIT:  if (advance) state_d = S_DRAW_HL;
            S_DRAW_HL:    if (advance) state_d = S_IDLE;
            S_IDLE: begin
                if (enter)      state_d = S_CHECK;
                else if (right) state_d = S_MOVE_R;
                else if (left)  state_d = S_MOVE_L;
                else if (up)    state_d = S_MOVE_U;
                else if (down)  state_d = S_MOVE_D;
            end
            S_MOVE_R, S_MOVE_L, S_MOVE_U, S_MOVE_D: state_d = S_DRAW_HL;
            S_CHECK:      if (advance) state_d = validMove ? S_PLACE : S_IDLE;
            S_PLACE:      if (advance) state_d = S_FLIP;
            S_FLIP:       if (advance) state_d = S_SCORE;
            S_SCORE:      if (advance) state_d = S_TURN;
            S_TURN:       if (advance) state_d = S_HAS_CUR;
            S_HAS_CUR:    if (advance) state_d = hasTurn ? S_DRAW_HL : S_HAS_OPP;
            S_HAS_OPP:    if (advance) state_d = hasTurn ? S_PASS : S_REMOVE_HL;
            S_PASS:       if (advance) state_d = S_DRAW_HL;
            S_REMOVE_HL:  if (advance) state_d = S_GAME_OVER;
            S_GAME_OVER:  if (enter) state_d = S_RESET;
            default:      state_d = state_q;
        endcase
        if (waiting && !advance && wdog_q == TO_LAST) state_d = S_ERROR;

        wdog_d = wdog_q;
        if (state_d != state_q)                wdog_d = '0;
        else if (waiting && wdog_q != TO_MAX)  wdog_d = wdog_q + 1'b1;

        player_d = player_q;
        if ((state_q == S_TURN || state_q == S_PASS) && state_d != state_q) player_d = ~player_q;
        if (state_d == S_RESET) player_d = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_RESET;
            wdog_q   <= '0;
            player_q <= 1'b0;
            out_q    <= decode(S_RESET);
        end else begin
            state_q  <= state_d;
            wdog_q   <= wdog_d;
            player_q <= player_d;
            out_q    <= decode(state_d);
        end
    end

    assign {dpReset, drawBoardEn, drawInitialPiecesEn, moveRightEn, moveLeftEn, moveUpEn,
            moveDownEn, moveHighlightEn, checkIfValidMoveEn, placeEn, flipEn, scoreManagerEn,
            determineHasTurnEn, determineCurrent, determineOpponent, TurnManagerEn,
            removeHighlightEn, writeEn, gameOver, error} = out_q;
    assign player = player_q;
    assign state  = state_q;
endmodule

// File: tb/tb_game_control.sv
// Testbench for game_control: scenario tasks plus a randomized run, all checked cycle by
// cycle against a name-based model of the game flow.
module tb_game_control;
    localparam int TO_W     = 4;
    localparam int WD_LIMIT = (1 << TO_W) - 1;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic enter = 1'b0, right = 1'b0, left = 1'b0, up = 1'b0, down = 1'b0;
    logic go = 1'b0, validMove = 1'b0, hasTurn = 1'b0;
    logic dpReset, drawBoardEn, drawInitialPiecesEn, moveRightEn, moveLeftEn, moveUpEn;
    logic moveDownEn, moveHighlightEn, checkIfValidMoveEn, placeEn, flipEn, scoreManagerEn;
    logic determineHasTurnEn, determineCurrent, determineOpponent, TurnManagerEn;
    logic removeHighlightEn, writeEn, player, gameOver, error;
    logic [4:0] state;
    logic [19:0] dut_outs;

    int    n_checks = 0;
    int    n_errors = 0;
    string m_state  = "RESET";
    int    m_dwell  = 1;
    logic  m_player = 1'b0;

    always #5 clk = ~clk;

    game_control #(.TO_W(TO_W)) dut (
        .clk(clk), .resetn(resetn), .enter(enter), .right(right), .left(left), .up(up),
        .down(down), .go(go), .validMove(validMove), .hasTurn(hasTurn),
        .dpReset(dpReset), .drawBoardEn(drawBoardEn), .drawInitialPiecesEn(drawInitialPiecesEn),
        .moveRightEn(moveRightEn), .moveLeftEn(moveLeftEn), .moveUpEn(moveUpEn),
        .moveDownEn(moveDownEn), .moveHighlightEn(moveHighlightEn),
        .checkIfValidMoveEn(checkIfValidMoveEn), .placeEn(placeEn), .flipEn(flipEn),
        .scoreManagerEn(scoreManagerEn), .determineHasTurnEn(determineHasTurnEn),
        .determineCurrent(determineCurrent), .determineOpponent(determineOpponent),
        .TurnManagerEn(TurnManagerEn), .removeHighlightEn(removeHighlightEn),
        .writeEn(writeEn), .player(player), .gameOver(gameOver), .error(error), .state(state)
    );

    assign dut_outs = {dpReset, drawBoardEn, drawInitialPiecesEn, moveRightEn, moveLeftEn,
                       moveUpEn, moveDownEn, moveHighlightEn, checkIfValidMoveEn, placeEn,
                       flipEn, scoreManagerEn, determineHasTurnEn, determineCurrent,
                       determineOpponent, TurnManagerEn, removeHighlightEn, writeEn,
                       gameOver, error};

    function automatic bit is_wait(string s);
        case (s)
            "RESET", "DRAW_BOARD", "DRAW_INIT", "DRAW_HL", "CHECK", "PLACE", "FLIP", "SCORE",
            "TURN", "HAS_CUR", "HAS_OPP", "PASS", "REMOVE_HL": return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Expected output vector for a state, bit order as dut_outs (dpReset at 19, error at 0).
    function automatic logic [19:0] model_outs(string s);
        logic [19:0] v;
        v = '0;
        case (s)
            "RESET":      v[19] = 1'b1;
            "DRAW_BOARD": begin v[18] = 1'b1; v[2] = 1'b1; end
            "DRAW_INIT":  begin v[17] = 1'b1; v[2] = 1'b1; end
            "MOVE_R":     v[16] = 1'b1;
            "MOVE_L":     v[15] = 1'b1;
            "MOVE_U":     v[14] = 1'b1;
            "MOVE_D":     v[13] = 1'b1;
            "DRAW_HL":    begin v[12] = 1'b1; v[2] = 1'b1; end
            "CHECK":      v[11] = 1'b1;
            "PLACE":      v[10] = 1'b1;
            "FLIP":       begin v[9] = 1'b1; v[2] = 1'b1; end
            "SCORE":      begin v[8] = 1'b1; v[2] = 1'b1; end
            "HAS_CUR":    begin v[7] = 1'b1; v[6] = 1'b1; end
            "HAS_OPP":    begin v[7] = 1'b1; v[5] = 1'b1; end
            "TURN", "PASS": v[4] = 1'b1;
            "REMOVE_HL":  begin v[3] = 1'b1; v[2] = 1'b1; end
            "GAME_OVER":  v[1] = 1'b1;
            "ERROR":      v[0] = 1'b1;
            default:      v = '0;
        endcase
        return v;
    endfunction

    // k = {enter, right, left, up, down}; m_dwell counts cycles spent in m_state, this one included.
    task automatic model_update(input logic [4:0] k, input logic g, input logic vm, input logic ht);
        string nxt;
        bit    adv;
        nxt = m_state;
        adv = is_wait(m_state) && m_dwell >= 2 && g;
        case (m_state)
            "RESET":      if (adv) nxt = "DRAW_BOARD";
            "DRAW_BOARD": if (adv) nxt = "DRAW_INIT";
            "DRAW_INIT":  if (adv) nxt = "DRAW_HL";
            "DRAW_HL":    if (adv) nxt = "IDLE";
            "IDLE": begin
                if (k[4])      nxt = "CHECK";
                else if (k[3]) nxt = "MOVE_R";
                else if (k[2]) nxt = "MOVE_L";
                else if (k[1]) nxt = "MOVE_U";
                else if (k[0]) nxt = "MOVE_D";
            end
            "MOVE_R", "MOVE_L", "MOVE_U", "MOVE_D": nxt = "DRAW_HL";
            "CHECK":      if (adv) begin if (vm) nxt = "PLACE"; else nxt = "IDLE"; end
            "PLACE":      if (adv) nxt = "FLIP";
            "FLIP":       if (adv) nxt = "SCORE";
            "SCORE":      if (adv) nxt = "TURN";
            "TURN":       if (adv) nxt = "HAS_CUR";
            "HAS_CUR":    if (adv) begin if (ht) nxt = "DRAW_HL"; else nxt = "HAS_OPP"; end
            "HAS_OPP":    if (adv) begin if (ht) nxt = "PASS"; else nxt = "REMOVE_HL"; end
            "PASS":       if (adv) nxt = "DRAW_HL";
            "REMOVE_HL":  if (adv) nxt = "GAME_OVER";
            "GAME_OVER":  if (k[4]) nxt = "RESET";
            default: ;
        endcase
        if (is_wait(m_state) && !adv && m_dwell >= WD_LIMIT) nxt = "ERROR";
        if ((m_state == "TURN" || m_state == "PASS") && nxt != m_state) m_player = ~m_player;
        if (nxt == "RESET") m_player = 1'b0;
        m_dwell = (nxt != m_state) ? 1 : m_dwell + 1;
        m_state = nxt;
    endtask

    // Called at a negedge; drives one cycle of inputs and returns at the following negedge.
    task automatic step(input logic [4:0] k, input logic g, input logic vm, input logic ht);
        {enter, right, left, up, down} = k;
        go = g; validMove = vm; hasTurn = ht;
        @(posedge clk);
        model_update(k, g, vm, ht);
        @(negedge clk);
        {enter, right, left, up, down} = 5'b0;
    endtask

    // Drops resetn mid low-phase and leaves it low; the caller checks before the next posedge.
    task automatic assert_reset();
        #1 resetn = 1'b0;
        m_state = "RESET"; m_dwell = 1; m_player = 1'b0;
        #2;
    endtask

    task automatic release_reset();
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({dut_outs, player} !== {20'h80000, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_state: got %b/%b exp %b/0", dut_outs, player, 20'h80000);
        end
        release_reset();
    endtask

    task automatic test_powerup();
        int cnt [4];
        int first [4];
        int idx [4];
        idx = '{19, 18, 17, 12};
        for (int j = 0; j < 4; j++) begin cnt[j] = 0; first[j] = -1; end
        for (int c = 0; c < 60 && m_state != "IDLE"; c++) begin
            for (int j = 0; j < 4; j++) if (dut_outs[idx[j]]) begin
                cnt[j]++;
                if (first[j] < 0) first[j] = c;
            end
            step(5'b0, m_dwell >= 3, 1'b0, 1'b0);
            n_checks++;
            if ({dut_outs, player} !== {model_outs(m_state), m_player}) begin
                n_errors++;
                $display("FAIL powerup %s: got %b/%b exp %b/%b", m_state, dut_outs, player, model_outs(m_state), m_player);
            end
        end
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (cnt[j] !== 3 || first[j] !== 3 * j) begin
                n_errors++;
                $display("FAIL powerup_dwell bit%0d: got %0d cycles from %0d exp 3 from %0d", idx[j], cnt[j], first[j], 3 * j);
            end
        end
    endtask

    task automatic test_key_priority();
        int gd;
        bit saw_place;
        gd = $urandom_range(1, 4);
        step(5'b01011, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({moveRightEn, moveUpEn, moveDownEn, dut_outs} !== {3'b100, model_outs("MOVE_R")}) begin
            n_errors++;
            $display("FAIL key_prio_move: got R%bU%bD%b outs %b exp only moveRightEn", moveRightEn, moveUpEn, moveDownEn, dut_outs);
        end
        step(5'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({moveRightEn, moveHighlightEn} !== 2'b01) begin
            n_errors++;
            $display("FAIL move_one_cycle: got moveRightEn=%b moveHighlightEn=%b exp 0/1", moveRightEn, moveHighlightEn);
        end
        for (int c = 0; c < 20 && m_state != "IDLE"; c++) begin
            step(5'b0, m_dwell >= gd, 1'b0, 1'b0);
            n_checks++;
            if ({dut_outs, player} !== {model_outs(m_state), m_player}) begin
                n_errors++;
                $display("FAIL key_prio_hl %s: got %b/%b exp %b/%b", m_state, dut_outs, player, model_outs(m_state), m_player);
            end
        end
        step(5'b10100, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({checkIfValidMoveEn, moveLeftEn} !== 2'b10) begin
            n_errors++;
            $display("FAIL enter_over_left: got check=%b left=%b exp 1/0", checkIfValidMoveEn, moveLeftEn);
        end
        saw_place = 1'b0;
        for (int c = 0; c < 20 && m_state != "IDLE"; c++) begin
            step(5'b0, m_dwell >= gd, 1'b0, 1'b0);
            if (placeEn) saw_place = 1'b1;
            n_checks++;
            if ({dut_outs, player} !== {model_outs(m_state), m_player}) begin
                n_errors++;
                $display("FAIL invalid_move %s: got %b/%b exp %b/%b", m_state, dut_outs, player, model_outs(m_state), m_player);
            end
        end
        n_checks++;
        if (saw_place !== 1'b0) begin
            n_errors++;
            $display("FAIL invalid_no_place: got placeEn seen=%b exp 0", saw_place);
        end
    endtask

    // Valid move; hasTurn values per HAS state set the path (mover keeps turn, pass, or game over).
    task automatic test_move(input string name, input logic ht_cur, input logic ht_opp,
                             input string stop_at, input logic exp_flip);
        int   gd;
        logic p0;
        gd = $urandom_range(1, 4);
        p0 = m_player;
        step(5'b10000, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 120 && m_state != stop_at; c++) begin
            step(5'b0, m_dwell >= gd, 1'b1, (m_state == "HAS_OPP") ? ht_opp : ht_cur);
            n_checks++;
            if ({dut_outs, player} !== {model_outs(m_state), m_player}) begin
                n_errors++;
                $display("FAIL %s %s: got %b/%b exp %b/%b", name, m_state, dut_outs, player, model_outs(m_state), m_player);
            end
        end
        n_checks++;
        if (player !== (p0 ^ exp_flip)) begin
            n_errors++;
            $display("FAIL %s_player: got %b exp %b", name, player, p0 ^ exp_flip);
        end
    endtask

    task automatic test_game_over();
        test_move("game_over", 1'b0, 1'b0, "GAME_OVER", 1'b1);
        for (int c = 0; c < 4; c++) begin
            step(5'($urandom_range(1, 15)), 1'b1, 1'b1, 1'b1);
            n_checks++;
            if (dut_outs !== 20'h00002) begin
                n_errors++;
                $display("FAIL game_over_hold: got %b exp %b", dut_outs, 20'h00002);
            end
        end
        step(5'b10000, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({dut_outs, player} !== {20'h80000, 1'b0}) begin
            n_errors++;
            $display("FAIL game_over_enter: got %b/%b exp %b/0", dut_outs, player, 20'h80000);
        end
    endtask

    // go held high: each wait state must still last exactly two cycles.
    task automatic test_back_to_back();
        int cnt [20];
        for (int j = 0; j < 20; j++) cnt[j] = 0;
        for (int pass_i = 0; pass_i < 2; pass_i++) begin
            if (pass_i == 1) step(5'b10000, 1'b1, 1'b1, 1'b1);
            for (int c = 0; c < 60 && m_state != "IDLE"; c++) begin
                for (int j = 0; j < 20; j++) if (dut_outs[j]) cnt[j]++;
                step(5'b0, 1'b1, 1'b1, 1'b1);
                n_checks++;
                if ({dut_outs, player} !== {model_outs(m_state), m_player}) begin
                    n_errors++;
                    $display("FAIL go_held %s: got %b/%b exp %b/%b", m_state, dut_outs, player, model_outs(m_state), m_player);
                end
            end
        end
        // Reset/board/init once; highlight twice; then the move chain once each.
        foreach (cnt[j]) begin
            int exp_c;
            case (j)
                19, 18, 17, 11, 10, 9, 8, 7, 6, 4: exp_c = 2;
                12:      exp_c = 4;
                2:       exp_c = 12;
                default: exp_c = 0;
            endcase
            n_checks++;
            if (cnt[j] !== exp_c) begin
                n_errors++;
                $display("FAIL go_held_dwell bit%0d: got %0d cycles exp %0d", j, cnt[j], exp_c);
            end
        end
    endtask

    task automatic test_watchdog();
        int flip_cnt;
        flip_cnt = 0;
        step(5'b10000, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 100 && m_state != "ERROR"; c++) begin
            if (flipEn) flip_cnt++;
            step(5'b0, (m_state != "FLIP") && m_dwell >= 2, 1'b1, 1'b1);
            n_checks++;
            if ({dut_outs, player} !== {model_outs(m_state), m_player}) begin
                n_errors++;
                $display("FAIL watchdog %s: got %b/%b exp %b/%b", m_state, dut_outs, player, model_outs(m_state), m_player);
            end
        end
        n_checks++;
        if (flip_cnt !== WD_LIMIT || dut_outs !== 20'h00001) begin
            n_errors++;
            $display("FAIL watchdog_trip: got %0d FLIP cycles outs %b exp %0d cycles outs %b", flip_cnt, dut_outs, WD_LIMIT, 20'h00001);
        end
        for (int c = 0; c < 6; c++) begin
            step(5'($urandom_range(1, 31)), 1'b1, 1'b1, 1'b1);
            n_checks++;
            if (dut_outs !== 20'h00001) begin
                n_errors++;
                $display("FAIL error_sticky: got %b exp %b", dut_outs, 20'h00001);
            end
        end
        assert_reset();
        n_checks++;
        if ({dut_outs, player} !== {20'h80000, 1'b0}) begin
            n_errors++;
            $display("FAIL async_reset: got %b/%b exp %b/0", dut_outs, player, 20'h80000);
        end
        release_reset();
    endtask

    task automatic test_random();
        logic [4:0] k;
        for (int c = 0; c < 600; c++) begin
            if (m_state == "ERROR" || $urandom_range(0, 149) == 0) begin
                assert_reset();
                n_checks++;
                if ({dut_outs, player} !== {20'h80000, 1'b0}) begin
                    n_errors++;
                    $display("FAIL rand_reset: got %b/%b exp %b/0", dut_outs, player, 20'h80000);
                end
                release_reset();
            end else begin
                k = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'b0;
                step(k, $urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom));
                n_checks++;
                if ({dut_outs, player} !== {model_outs(m_state), m_player}) begin
                    n_errors++;
                    $display("FAIL random c%0d %s: got %b/%b exp %b/%b", c, m_state, dut_outs, player, model_outs(m_state), m_player);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_key_priority();
        test_move("place_flow", 1'b1, 1'b0, "IDLE", 1'b1);
        test_move("pass_flow", 1'b0, 1'b1, "IDLE", 1'b0);
        test_game_over();
        test_back_to_back();
        test_watchdog();
        test_powerup();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
